// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO helpers: clog2, width derivations, parameter-check macro
//
// Contents:
//   clog2(value)    ceiling log2, usable in constant expressions
//   addr_w(depth)   pointer width for a FIFO of 'depth' entries
//   cnt_w(depth)    occupancy counter width (holds 0..depth inclusive)
//   FIFO_PARAM_CHECK(DEPTH, AE, AF)  generate-scope elaboration check; fatal on
//                   non-power-of-two depth, depth < 4, or bad AE/AF ordering

`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

`define FIFO_PARAM_CHECK(DEPTH, AE, AF) \
    if (((DEPTH) < 4) || (((DEPTH) & ((DEPTH) - 1)) != 0)) begin : g_bad_depth \
        $fatal(1, "FIFO_DEPTH must be a power of two and at least 4"); \
    end \
    if (!(((AE) < (AF)) && ((AF) <= (DEPTH)))) begin : g_bad_levels \
        $fatal(1, "thresholds must satisfy AE_LEVEL < AF_LEVEL <= FIFO_DEPTH"); \
    end

package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    function automatic int addr_w(input int depth);
        return clog2(depth);
    endfunction

    // One extra bit so that a completely full FIFO (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_DEPTH  = 32;
    localparam int DEFAULT_ADDR_W = addr_w(DEFAULT_DEPTH);
    localparam int DEFAULT_CNT_W  = cnt_w(DEFAULT_DEPTH);

endpackage

`endif

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - two-port storage array, synchronous write, asynchronous read
//
// Parameters: DATA_WIDTH word width, DEPTH entries, ADDR_W address width
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational so the owner can register it or fall through

module fifo_mem_2p #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    // No reset: contents are don't-care until written.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_status.sv
// rtl/sync_fifo_status.sv - single-clock FIFO with occupancy count, thresholds and sticky errors
//
// Build option: SYNC_FIFO_FWFT_EN selects first-word-fall-through reads (zero latency,
// re acknowledges the head). Undefined: data_out registered, one cycle after re.
//
// Parameters: DATA_WIDTH, FIFO_DEPTH (power of two, >= 4), AF_LEVEL, AE_LEVEL
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous active-low reset
//   we, data_in   in   write request and data
//   re            in   read request (acknowledge in FWFT mode)
//   clr_err       in   clears overrun/underrun
//   data_out      out  read data
//   full, empty   out  count == FIFO_DEPTH / count == 0
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  occupancy 0..FIFO_DEPTH
//   overrun       out  sticky: a write was dropped
//   underrun      out  sticky: a read was rejected

module sync_fifo_status
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32,
    parameter int AF_LEVEL   = FIFO_DEPTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               we,
    input  logic [DATA_WIDTH-1:0]              data_in,
    input  logic                               re,
    input  logic                               clr_err,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]        count,
    output logic                               overrun,
    output logic                               underrun
);

    localparam int ADDR_W = addr_w(FIFO_DEPTH);
    localparam int CNT_W  = cnt_w(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

    `FIFO_PARAM_CHECK(FIFO_DEPTH, AE_LEVEL, AF_LEVEL)

    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  set_overrun;
    logic                  set_underrun;

    // Flags derive from the counter alone; pointers are equal both when empty and full.
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;

    assign rd_ok = re && !empty;
    // A full FIFO can still take a write when a read frees the head slot this cycle.
    assign wr_ok = we && (!full || re);

    assign set_overrun  = we && full && !re;
    assign set_underrun = re && empty;

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count_q <= count_q + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // A new error in the same cycle as clr_err leaves the flag set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (set_overrun) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (set_underrun) begin
                underrun <= 1'b1;
            end else if (clr_err) begin
                underrun <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word falls through; masked to zero so an empty FIFO never shows stale data.
    assign data_out = empty ? '0 : mem_rdata;
`else
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (rd_ok) begin
            rd_data_q <= mem_rdata;
        end
    end

    assign data_out = rd_data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_status.sv
// tb/tb_sync_fifo_status.sv - self-checking bench for sync_fifo_status (depth 32)

module tb_sync_fifo_status;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AF    = DEPTH - 4;
    localparam int AE    = 4;

    logic          clk;
    logic          reset;
    logic          we;
    logic [DW-1:0] data_in;
    logic          re;
    logic          clr_err;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [5:0]    count;
    logic          overrun;
    logic          underrun;

    sync_fifo_status #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .we           (we),
        .data_in      (data_in),
        .re           (re),
        .clr_err      (clr_err),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overrun      (overrun),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic          re;
        logic          clr;
        logic [DW-1:0] din;
        int            exp_count;
        logic          exp_ovr;
        logic          exp_und;
        string         name;
    } vec_t;

    vec_t          tbl[$];
    logic [DW-1:0] mq[$];     // reference FIFO contents
    logic [DW-1:0] sb[$];     // expected read data awaiting the DUT
    logic [DW-1:0] last_data;
    int            checks;
    int            errors;

    function automatic vec_t mk(logic w, logic r, logic c, logic [DW-1:0] d,
                                int cnt, logic ovr, logic und, string nm);
        vec_t v;
        v.we = w; v.re = r; v.clr = c; v.din = d;
        v.exp_count = cnt; v.exp_ovr = ovr; v.exp_und = und; v.name = nm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_status(input string nm, input int cnt, input logic ovr, input logic und);
        chk({nm, " count"}, 32'(count), 32'(cnt));
        chk({nm, " full"}, 32'(full), 32'(cnt == DEPTH));
        chk({nm, " empty"}, 32'(empty), 32'(cnt == 0));
        chk({nm, " almost_full"}, 32'(almost_full), 32'(cnt >= AF));
        chk({nm, " almost_empty"}, 32'(almost_empty), 32'(cnt <= AE));
        chk({nm, " overrun"}, 32'(overrun), 32'(ovr));
        chk({nm, " underrun"}, 32'(underrun), 32'(und));
    endtask

    task automatic apply(input vec_t v);
        logic rd_ok;
        logic wr_ok;
        @(negedge clk);
        we = v.we; re = v.re; clr_err = v.clr; data_in = v.din;
        rd_ok = v.re && (mq.size() != 0);
        wr_ok = v.we && ((mq.size() < DEPTH) || v.re);
`ifdef SYNC_FIFO_FWFT_EN
        chk({v.name, " fwft head"}, data_out, (mq.size() != 0) ? mq[0] : '0);
`endif
        if (rd_ok) sb.push_back(mq.pop_front());
        if (wr_ok) mq.push_back(v.din);
        @(posedge clk);
        #1;
        chk_status(v.name, v.exp_count, v.exp_ovr, v.exp_und);
`ifdef SYNC_FIFO_FWFT_EN
        sb.delete();
`else
        if (sb.size() != 0) last_data = sb.pop_front();
        chk({v.name, " data_out"}, data_out, last_data);
`endif
        we = 1'b0; re = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mq.delete();
        sb.delete();
        last_data = '0;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; we = 1'b0; re = 1'b0; clr_err = 1'b0; data_in = '0;
        last_data = '0;

        // Fill, overflow, clear, full read+write, drain, empty corner cases.
        for (int i = 0; i < DEPTH; i++)
            tbl.push_back(mk(1, 0, 0, 32'(i + 1), i + 1, 0, 0, "fill"));
        tbl.push_back(mk(1, 0, 0, 32'hDEAD, 32, 1, 0, "full_write_drop"));
        tbl.push_back(mk(0, 0, 1, 32'h0, 32, 0, 0, "clr_overrun"));
        tbl.push_back(mk(1, 1, 0, 32'hBEEF, 32, 0, 0, "full_rw"));
        for (int i = 0; i < DEPTH; i++)
            tbl.push_back(mk(0, 1, 0, 32'h0, DEPTH - 1 - i, 0, 0, "drain"));
        tbl.push_back(mk(1, 1, 0, 32'h55, 1, 0, 1, "empty_rw"));
        tbl.push_back(mk(0, 1, 0, 32'h0, 0, 0, 1, "read_55"));
        tbl.push_back(mk(0, 0, 1, 32'h0, 0, 0, 0, "clr_underrun"));
        tbl.push_back(mk(0, 1, 1, 32'h0, 0, 0, 1, "clr_vs_new_err"));
        tbl.push_back(mk(0, 0, 1, 32'h0, 0, 0, 0, "clr_again"));

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk_status("reset", 0, 0, 0);
        chk("reset data_out", data_out, 32'h0);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Reset in the middle of a stream abandons contents and zeroes data_out.
        for (int i = 0; i < 10; i++)
            apply(mk(1, (i == 5), 0, 32'h100 + 32'(i), (i < 5) ? i + 1 : i, 0, 0, "pre_reset"));
        @(negedge clk);
        we = 1'b1; data_in = 32'h777;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1; we = 1'b0;
        mq.delete(); sb.delete(); last_data = '0;
        chk_status("mid_reset", 0, 0, 0);
        chk("mid_reset data_out", data_out, 32'h0);

        apply(mk(1, 0, 0, 32'hA5, 1, 0, 0, "post_reset_wr"));
`ifdef SYNC_FIFO_FWFT_EN
        chk("fwft A5 visible", data_out, 32'hA5);
`endif
        apply(mk(0, 1, 0, 32'h0, 0, 0, 0, "post_reset_rd"));
        chk("post_reset A5", data_out, 32'hA5);

        do_reset();
        chk_status("final_reset", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_status.md
Name: sync_fifo_status

Overview:
- Parametrised single-clock FIFO. Next generation of the team's generic FIFO.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overrun/underrun error flags with clear, and correct full/empty at every depth.
- Sits between producer and consumer blocks in the verification DUT set. Drop-in for the generic FIFO, plus status outputs.

Parameters:
- DATA_WIDTH, 32, word width in bits (>=1)
- FIFO_DEPTH, 32, number of storage entries; power of two, >=4
- AF_LEVEL, FIFO_DEPTH-4, almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- we  input  1  write request
- data_in  input  DATA_WIDTH  write data
- re  input  1  read request
- clr_err  input  1  clears the sticky overrun/underrun flags
- data_out  output  DATA_WIDTH  read data
- full  output  1  count == FIFO_DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
- overrun  output  1  sticky: a write was dropped
- underrun  output  1  sticky: a read was rejected

Behaviour:
- Interface: reset reset, synchronous, active-low; clock clk. Reset has priority over all other inputs.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, data_out=0, overrun=0, underrun=0. Hence empty=1, full=0, almost_empty=1, almost_full=0.
- Pointers: ADDR_W=$clog2(FIFO_DEPTH) bits, natural wrap from FIFO_DEPTH-1 to 0. Full/empty come from the count register only, never from pointer comparison.
- Read accept: rd_ok = re && !empty. On rd_ok, data_out <= mem[rd_ptr] and rd_ptr increments. Latency is one cycle from re to data_out. data_out holds its value when no read is accepted.
- Write accept: wr_ok = we && (!full || re). A write is allowed while full if a read is accepted in the same cycle. On wr_ok, mem[wr_ptr] <= data_in and wr_ptr increments.
- Empty with we && re: the write is accepted, the read is rejected, and underrun is set. No write-through bypass.
- Count update:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged when both or neither occur
  - count never exceeds FIFO_DEPTH and never goes below 0
- Errors:
  - overrun <= 1 when we && full && !re
  - underrun <= 1 when re && empty
  - Both flags are sticky until clr_err=1 or reset.
  - If clr_err and a new error occur in the same cycle, the new error wins (flag ends at 1).
- Status flags are combinational from the count register and valid in the cycle after the causing edge.
- Reset mid-operation: contents are abandoned (memory is not cleared). The FIFO reads as empty and the pending data_out is zeroed.
- Parameter checks at elaboration:
  - FIFO_DEPTH must be a power of two
  - AE_LEVEL < AF_LEVEL <= FIFO_DEPTH
  - a violation is a fatal error.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN
- Defined: first-word-fall-through.
  - data_out = mem[rd_ptr] combinationally whenever !empty, and 0 when empty.
  - re acts as an acknowledge: it pops the head and the next word appears in the same cycle after the edge.
  - Read latency is zero. All accept/error rules are unchanged.
- Undefined: registered read with one-cycle latency, as described above.

Decomposition:
- Shared package fifo_pkg:
  - function clog2
  - localparam derivations ADDR_W and CNT_W
  - parameter-check macro, reused by future FIFO variants
- Sub-module fifo_mem_2p:
  - DATA_WIDTH x FIFO_DEPTH array
  - one synchronous write port, one read address port
  - the read is asynchronous so that the top level can register it or use FWFT
- Pointer, count, flag and error logic stay in sync_fifo_status.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, count=0, data_out=0, overrun=0, underrun=0.
- Write 0x1..0x20 (32 words, depth 32) -> full=1 and count=32 after the 32nd write; almost_full first seen at count=28. Then 32 reads return 0x1..0x20 in order, each one cycle after re; empty=1 at the end.
- With full, pulse we alone with 0xDEAD -> write dropped, overrun=1, count=32. Pulse clr_err -> overrun=0.
- With full, we=re=1 with 0xBEEF -> the head word is read, 0xBEEF is stored, count stays 32, no overrun.
- With empty, we=re=1 with 0x55 -> count=1, underrun=1, data_out unchanged. The next read returns 0x55.
- Write 10 words, assert reset for 1 cycle mid-stream -> count=0, empty=1, data_out=0. The next write/read of 0xA5 returns 0xA5. Under SYNC_FIFO_FWFT_EN, 0xA5 is visible on data_out the cycle after the write.
